// File: rtl/edge_map_lap3.sv
// Streaming 3x3 Laplacian edge map over raster-order AXI-stream frames of packed pixels.
// Output pixel = saturated |4C - N - S - W - E| with zero padding outside the image.
module edge_map_lap3 #(
   parameter int IM_LEN     = 520,
   parameter int IM_WID     = 520,
   parameter int DATA_WIDTH = 128,
   parameter int PIX_WIDTH  = 16
) (
   input  logic                  s_axis_clk,
   input  logic                  s_axis_aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_err
);

   localparam int PIX_PER_BEAT = DATA_WIDTH / PIX_WIDTH;
   localparam int BPR          = IM_WID / PIX_PER_BEAT;
   localparam int N_BEATS      = IM_LEN * BPR;
   localparam int WIN_D        = 2 * BPR + 1;
   localparam int CW           = $clog2(N_BEATS + 1);
   localparam int RW           = $clog2(IM_LEN + 1);
   localparam int BW           = $clog2(BPR + 1);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                  state_r, state_nx;
   logic [CW-1:0]           in_cnt_r;
   logic [RW-1:0]           out_row_r;
   logic [BW-1:0]           out_bcol_r;
   logic                    rdy_r;
   logic                    m_valid_r, m_last_r, frame_err_r;
   logic [DATA_WIDTH-1:0]   m_data_r;
   logic [DATA_WIDTH-1:0]   win_r [WIN_D];

   logic                    en_s, acc_s, inj_s, shift_s, produce_s;
   logic                    in_last_s, out_last_s;
   logic                    top_row_s, bot_row_s, first_col_s, last_col_s;
   logic [DATA_WIDTH-1:0]   shift_data_s, north_s, south_s, lap_beat_s;
   logic [PIX_WIDTH-1:0]    west_pix_s, east_pix_s;
   logic [(PIX_PER_BEAT+2)*PIX_WIDTH-1:0] row_ext_s;

   // Signed Laplacian at PIX_WIDTH+3 bits, magnitude saturated to the pixel range.
   function automatic logic [PIX_WIDTH-1:0] lap_pix(
      input logic [PIX_WIDTH-1:0] c,
      input logic [PIX_WIDTH-1:0] n,
      input logic [PIX_WIDTH-1:0] s,
      input logic [PIX_WIDTH-1:0] w,
      input logic [PIX_WIDTH-1:0] e
   );
      logic signed [PIX_WIDTH+2:0] sum;
      logic        [PIX_WIDTH+2:0] mag;
      sum = $signed({1'b0, c, 2'b00}) - $signed({3'b000, n}) - $signed({3'b000, s})
          - $signed({3'b000, w}) - $signed({3'b000, e});
      mag = sum[PIX_WIDTH+2] ? $unsigned(-sum) : $unsigned(sum);
      if (|mag[PIX_WIDTH+2:PIX_WIDTH]) begin
         lap_pix = {PIX_WIDTH{1'b1}};
      end else begin
         lap_pix = mag[PIX_WIDTH-1:0];
      end
   endfunction

   assign en_s          = ~m_valid_r | m_axis_tready;
   assign s_axis_tready = en_s & rdy_r & (state_r != ST_FLUSH);
   assign acc_s         = s_axis_tvalid & s_axis_tready;
   assign inj_s         = en_s & (state_r == ST_FLUSH);
   assign shift_s       = acc_s | inj_s;
   assign shift_data_s  = acc_s ? s_axis_tdata : {DATA_WIDTH{1'b0}};
   assign in_last_s     = (in_cnt_r == CW'(N_BEATS - 1));
   assign top_row_s     = (out_row_r == RW'(0));
   assign bot_row_s     = (out_row_r == RW'(IM_LEN - 1));
   assign first_col_s   = (out_bcol_r == BW'(0));
   assign last_col_s    = (out_bcol_r == BW'(BPR - 1));
   assign out_last_s    = bot_row_s & last_col_s;

   // Next-state and output-produce decode.
   always_comb begin
      state_nx  = state_r;
      produce_s = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (acc_s && (in_cnt_r == CW'(BPR))) begin
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_FILL;
            end
         end
         ST_RUN: begin
            produce_s = acc_s;
            if (acc_s && in_last_s) begin
               state_nx = ST_FLUSH;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_FLUSH: begin
            produce_s = inj_s;
            if (inj_s && out_last_s) begin
               state_nx = ST_FILL;
            end else begin
               state_nx = ST_FLUSH;
            end
         end
         default: begin
            state_nx  = ST_FILL;
            produce_s = 1'b0;
         end
      endcase
   end

   // Neighbourhood gather: borders are masked by the output position, never by window contents.
   always_comb begin
      north_s    = top_row_s   ? {DATA_WIDTH{1'b0}} : win_r[2*BPR];
      south_s    = bot_row_s   ? {DATA_WIDTH{1'b0}} : win_r[0];
      west_pix_s = first_col_s ? {PIX_WIDTH{1'b0}}  : win_r[BPR+1][DATA_WIDTH-1 -: PIX_WIDTH];
      east_pix_s = last_col_s  ? {PIX_WIDTH{1'b0}}  : win_r[BPR-1][PIX_WIDTH-1:0];
      row_ext_s  = {east_pix_s, win_r[BPR], west_pix_s};
      lap_beat_s = {DATA_WIDTH{1'b0}};
      for (int p = 0; p < PIX_PER_BEAT; p++) begin
         lap_beat_s[p*PIX_WIDTH +: PIX_WIDTH] = lap_pix(
            row_ext_s[(p+1)*PIX_WIDTH +: PIX_WIDTH],
            north_s[p*PIX_WIDTH +: PIX_WIDTH],
            south_s[p*PIX_WIDTH +: PIX_WIDTH],
            row_ext_s[p*PIX_WIDTH +: PIX_WIDTH],
            row_ext_s[(p+2)*PIX_WIDTH +: PIX_WIDTH]);
      end
   end

   // State register.
   always_ff @(posedge s_axis_clk) begin
      if (!s_axis_aresetn) begin
         state_r <= ST_FILL;
      end else begin
         state_r <= state_nx;
      end
   end

   // Input beat counter, ready enable and framing check.
   always_ff @(posedge s_axis_clk) begin
      if (!s_axis_aresetn) begin
         in_cnt_r    <= {CW{1'b0}};
         rdy_r       <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rdy_r       <= 1'b1;
         frame_err_r <= acc_s & (s_axis_tlast ^ in_last_s);
         if (acc_s) begin
            in_cnt_r <= in_last_s ? {CW{1'b0}} : in_cnt_r + CW'(1);
         end
      end
   end

   // Output position counters used for border masking and tlast.
   always_ff @(posedge s_axis_clk) begin
      if (!s_axis_aresetn) begin
         out_row_r  <= {RW{1'b0}};
         out_bcol_r <= {BW{1'b0}};
      end else if (produce_s) begin
         if (last_col_s) begin
            out_bcol_r <= {BW{1'b0}};
            out_row_r  <= bot_row_s ? {RW{1'b0}} : out_row_r + RW'(1);
         end else begin
            out_bcol_r <= out_bcol_r + BW'(1);
         end
      end
   end

   // Beat window: win_r[0] is the newest beat; contents need no reset.
   always_ff @(posedge s_axis_clk) begin
      if (shift_s) begin
         win_r[0] <= shift_data_s;
         for (int i = 1; i < WIN_D; i++) begin
            win_r[i] <= win_r[i-1];
         end
      end
   end

   // Registered output stage; holds while downstream stalls.
   always_ff @(posedge s_axis_clk) begin
      if (!s_axis_aresetn) begin
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_data_r  <= {DATA_WIDTH{1'b0}};
      end else if (en_s) begin
         m_valid_r <= produce_s;
         m_last_r  <= produce_s & out_last_s;
         if (produce_s) begin
            m_data_r <= lap_beat_s;
         end
      end
   end

   assign m_axis_tdata  = m_data_r;
   assign m_axis_tvalid = m_valid_r;
   assign m_axis_tlast  = m_last_r;
   assign frame_err     = frame_err_r;

endmodule
